// File: rtl/kianv_arb_pkg.sv
// Shared types and helpers for the kianv memory-port arbiter.
// State encodings are fixed because grant/state values are visible on debug taps.
package kianv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/kianv_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
// Rotates the request vector so the priority encoder always scans from bit 0.
module kianv_rr_pick
    import kianv_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int unsigned    base;
    logic           found;

    always_comb begin
        dbl   = {req, req};
        base  = (32'(last) + 1) % N;
        rot   = dbl[base +: N];
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                idx   = IW'((base + i) % N);
            end
        end
    end

endmodule

// File: rtl/kianv_mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port among NUM_MASTERS requesters.
// A per-master lock holds the grant across back-to-back accesses (AMO pairs, PTW walks).
module kianv_mem_arbiter
    import kianv_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 34,
    parameter int unsigned DATA_WIDTH  = 32,
    localparam int unsigned GW = clog2(NUM_MASTERS),
    localparam int unsigned SW = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_MASTERS-1:0]            s_valid,
    input  logic [NUM_MASTERS-1:0]            s_lock,
    input  logic [NUM_MASTERS*SW-1:0]         s_wstrb,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
    output logic [NUM_MASTERS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [NUM_MASTERS-1:0]            s_access_fault,
    output logic                              mem_valid,
    input  logic                              mem_ready,
    output logic [SW-1:0]                     mem_wstrb,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              access_fault,
    output logic [GW-1:0]                     grant
);

    arb_state_e    state, state_nxt;
    logic [GW-1:0] grant_nxt;
    logic [GW-1:0] last, last_nxt;
    logic          pick_any;
    logic [GW-1:0] pick_idx;

    kianv_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req  (s_valid),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // last resets to N-1 so master 0 has top priority out of reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            last  <= GW'(NUM_MASTERS - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_nxt       = last;
        mem_valid      = 1'b0;
        s_ready        = '0;
        s_access_fault = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_valid             = 1'b1;
                s_ready[grant]        = mem_ready;
                s_access_fault[grant] = access_fault & mem_ready;
                if (mem_ready) begin
                    last_nxt  = grant;
                    state_nxt = s_lock[grant] ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // a pending access wins over a dropped lock; lock is re-sampled at its completion
                if (s_valid[grant]) begin
                    state_nxt = BUSY;
                end else if (!s_lock[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = s_addr[32'(grant) * ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = s_wdata[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
        mem_wstrb = s_wstrb[32'(grant) * SW +: SW];
        s_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_kianv_mem_arbiter.sv
// Directed bench for kianv_mem_arbiter (4 masters): scripted masters, a wait-state
// slave model, and an in-order completion scoreboard.
module tb_kianv_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 34;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = 2;

    typedef struct {
        int unsigned   m;
        logic [AW-1:0] addr;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
        logic          lock;
    } req_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    s_valid, s_lock, s_ready, s_access_fault;
    logic [N*SW-1:0] s_wstrb;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            mem_valid, mem_ready, access_fault;
    logic [SW-1:0]   mem_wstrb;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [GW-1:0]   grant;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int          cyc = 0;
    int          last_done = -1;
    logic        gap_chk = 1'b0;

    req_t        req_q[N][$];
    req_t        exp_q[$];
    req_t        cur[N];
    logic [N-1:0] active;
    logic [N-1:0] rdy_seen;

    int unsigned wait_n = 0;
    logic        slave_en = 1'b0;
    int unsigned wcnt;

    always #5 clk = ~clk;

    kianv_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_valid        (s_valid),
        .s_lock         (s_lock),
        .s_wstrb        (s_wstrb),
        .s_addr         (s_addr),
        .s_wdata        (s_wdata),
        .s_ready        (s_ready),
        .s_rdata        (s_rdata),
        .s_access_fault (s_access_fault),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_wstrb      (mem_wstrb),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .access_fault   (access_fault),
        .grant          (grant)
    );

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return a[31:0] ^ 32'h5A5A_1234 ^ {30'b0, a[AW-1:AW-2]};
    endfunction

    function automatic logic fault_model(input logic [AW-1:0] a);
        return a[AW-1:AW-2] == 2'b11;
    endfunction

    // slave: asserts ready after wait_n stall cycles, faults on the top PA quadrant
    always @(posedge clk) begin
        if (!resetn) wcnt <= 0;
        else if (mem_valid && mem_ready) wcnt <= 0;
        else if (mem_valid) wcnt <= wcnt + 1;
    end
    assign mem_ready    = slave_en && mem_valid && (wcnt >= wait_n);
    assign access_fault = mem_valid && fault_model(mem_addr);
    assign mem_rdata    = rd_model(mem_addr);

    function automatic req_t mk(input int unsigned m, input logic [AW-1:0] a,
                                input logic [SW-1:0] st, input logic [DW-1:0] wd, input logic lk);
        req_t r;
        r.m = m; r.addr = a; r.wstrb = st; r.wdata = wd; r.lock = lk;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input req_t r);
        req_q[r.m].push_back(r);
        exp_q.push_back(r);
    endtask

    task automatic tick();
        req_t e;
        @(posedge clk);
        #1;
        for (int m = 0; m < N; m++) begin
            if (rdy_seen[m]) active[m] = 1'b0;
            if (!active[m] && req_q[m].size() > 0) begin
                cur[m]    = req_q[m].pop_front();
                active[m] = 1'b1;
            end
            s_valid[m]          = active[m];
            s_lock[m]           = active[m] & cur[m].lock;
            s_addr[m*AW +: AW]  = active[m] ? cur[m].addr  : '0;
            s_wstrb[m*SW +: SW] = active[m] ? cur[m].wstrb : '0;
            s_wdata[m*DW +: DW] = active[m] ? cur[m].wdata : '0;
        end
        cyc++;
        @(negedge clk);
        rdy_seen = s_ready;
        chk("ready_onehot0", 64'($onehot0(s_ready)), 64'd1);
        chk("fault_unqualified", 64'(s_access_fault & ~s_ready), 64'd0);
        if (s_ready != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 64'(s_ready), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ready_owner", 64'(s_ready), 64'(1) << e.m);
                chk("grant", 64'(grant), 64'(e.m));
                chk("mem_valid_busy", 64'(mem_valid), 64'd1);
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                chk("s_rdata", 64'(s_rdata), 64'(rd_model(e.addr)));
                chk("s_access_fault", 64'(s_access_fault),
                    fault_model(e.addr) ? (64'(1) << e.m) : 64'd0);
                if (gap_chk && last_done >= 0) chk("access_gap", 64'(cyc - last_done), 64'd2);
                last_done = cyc;
            end
        end
    endtask

    function automatic logic tb_busy();
        logic b;
        b = (exp_q.size() > 0) || (active != '0);
        for (int m = 0; m < N; m++) if (req_q[m].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run(input int unsigned maxc);
        int unsigned n;
        n = 0;
        while (tb_busy() && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic abandon();
        for (int m = 0; m < N; m++) req_q[m].delete();
        exp_q.delete();
        active   = '0;
        rdy_seen = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_fault", 64'(s_access_fault), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        resetn = 1'b1;
    endtask

    initial begin
        req_t a, b, c;
        resetn = 1'b0;
        s_valid = '0; s_lock = '0; s_addr = '0; s_wstrb = '0; s_wdata = '0;
        active = '0; rdy_seen = '0;
        for (int m = 0; m < N; m++) cur[m] = mk(0, '0, '0, '0, 1'b0);

        // 1: single read, 1-wait slave, one cycle request-to-mem_valid latency
        do_reset();
        slave_en = 1'b1; wait_n = 1;
        send(mk(0, 34'h0_8000_0000, 4'h0, 32'h0, 1'b0));
        tick();
        chk("t1_latency_idle", 64'(mem_valid), 64'd0);
        tick();
        chk("t1_mem_valid", 64'(mem_valid), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h0_8000_0000);
        chk("t1_wait_no_ready", 64'(s_ready), 64'd0);
        tick();
        tick();
        chk("t1_after_ready", 64'(s_ready), 64'd0);
        chk("t1_after_valid", 64'(mem_valid), 64'd0);
        run(20);

        // 2: masters 0 and 1 continuously requesting, 0-wait; last=0 so master 1 leads
        wait_n = 0; gap_chk = 1'b1; last_done = -1;
        for (int k = 0; k < 3; k++) begin
            a = mk(1, 34'h0_8000_0100 + 34'(k*4), 4'h0, 32'h0, 1'b0);
            b = mk(0, 34'h0_8000_0200 + 34'(k*4), 4'h3, 32'hA000_0000 + 32'(k), 1'b0);
            req_q[1].push_back(a); req_q[0].push_back(b);
            exp_q.push_back(a);    exp_q.push_back(b);
        end
        run(60);
        gap_chk = 1'b0;

        // 3: master 1 locked read+write pair while master 0 waits
        wait_n = 1;
        a = mk(1, 34'h0_8000_1000, 4'h0, 32'h0, 1'b1);
        b = mk(1, 34'h0_8000_1000, 4'hF, 32'hDEAD_BEEF, 1'b0);
        c = mk(0, 34'h0_8000_2000, 4'h0, 32'h0, 1'b0);
        req_q[1].push_back(a); req_q[1].push_back(b); req_q[0].push_back(c);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        run(60);

        // 3b: locked access with no follow-up releases the lock once it drops
        a = mk(1, 34'h0_8000_1004, 4'h0, 32'h0, 1'b1);
        c = mk(0, 34'h0_8000_2004, 4'h1, 32'h55, 1'b0);
        req_q[1].push_back(a); req_q[0].push_back(c);
        exp_q.push_back(a); exp_q.push_back(c);
        run(60);

        // 4: faulting write from master 1
        wait_n = 0;
        send(mk(1, 34'h3_0000_0010, 4'hF, 32'h1234_5678, 1'b0));
        run(20);
        tick();
        chk("t4_no_residual_fault", 64'(s_access_fault), 64'd0);

        // 5: reset during BUSY with a stalled slave
        slave_en = 1'b0;
        req_q[1].push_back(mk(1, 34'h0_8000_3000, 4'h0, 32'h0, 1'b0));
        tick(); tick(); tick();
        chk("t5_busy_valid", 64'(mem_valid), 64'd1);
        chk("t5_busy_grant", 64'(grant), 64'd1);
        abandon();
        resetn = 1'b0;
        tick();
        chk("t5_rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
        chk("t5_rst_grant", 64'(grant), 64'd0);
        resetn = 1'b1;
        slave_en = 1'b1; wait_n = 0;
        a = mk(0, 34'h0_8000_4000, 4'h0, 32'h0, 1'b0);
        b = mk(1, 34'h0_8000_4100, 4'h0, 32'h0, 1'b0);
        req_q[1].push_back(b); req_q[0].push_back(a);
        exp_q.push_back(a); exp_q.push_back(b);
        run(30);

        // 6: masters 1 and 3 from reset (last=3): order 1,3,1
        do_reset();
        a = mk(1, 34'h0_8000_5000, 4'h0, 32'h0, 1'b0);
        b = mk(3, 34'h0_8000_5300, 4'hC, 32'hCAFE_0000, 1'b0);
        c = mk(1, 34'h0_8000_5004, 4'h0, 32'h0, 1'b0);
        req_q[1].push_back(a); req_q[1].push_back(c); req_q[3].push_back(b);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
